// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer: I2S master transmitter.
// Parallel stereo pairs enter a small FIFO through a valid/ready handshake.
// BCK and WS are derived from i_clk, and DATA is shifted out MSB-first, left
// slot then right slot. o_ws and o_data change only when BCK falls.
// Optional macro: I2S_TX_LEFT_JUSTIFIED_EN selects left-justified WS timing
// (WS changes with the MSB). When it is undefined, standard I2S timing is used
// (WS leads the MSB by one bit).
module i2s_tx_serializer #(
  parameter int SAMPLE_W   = 24,
  parameter int SLOT_W     = 32,
  parameter int BCK_HALF   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_enable,
  input  logic [SAMPLE_W-1:0]           i_left,
  input  logic [SAMPLE_W-1:0]           i_right,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic                          o_bck,
  output logic                          o_ws,
  output logic                          o_data,
  output logic                          o_underrun,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int FRAME_W = 2 * SLOT_W;
  localparam int PW      = $clog2(FRAME_W);
  localparam int CW      = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;
  localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW      = $clog2(FIFO_DEPTH) + 1;
  localparam int PAIR_W  = 2 * SAMPLE_W;

  // Reset and disable both return the block to its idle state.
  logic                 clear_s;

  // BCK divider.
  logic [CW-1:0]        cnt_r;
  logic                 bck_r;
  logic                 tick_s;
  logic                 fall_s;

  // Bit position within the stereo frame and the frame shifter.
  logic [PW-1:0]        p_r;
  logic [PW-1:0]        p_next_s;
  logic                 load_s;
  logic [FRAME_W-1:0]   shreg_r;
  logic [FRAME_W-1:0]   frame_s;
  logic                 ws_r;
  logic                 ws_next_s;
  logic                 data_r;
  logic                 underrun_r;

  // Sample-pair FIFO.
  logic [PAIR_W-1:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_r;
  logic [AW-1:0]        rd_ptr_r;
  logic [LW-1:0]        level_r;
  logic [PAIR_W-1:0]    head_s;
  logic                 empty_s;
  logic                 full_s;
  logic                 ready_s;
  logic                 push_s;
  logic                 pop_s;

  // Decode the divider wrap and the BCK falling event.
  always_comb begin
    clear_s = i_rst || !i_enable;
    tick_s  = (cnt_r == CW'(BCK_HALF - 1));
    fall_s  = tick_s && bck_r;
  end

  // Advance the bit position modulo the frame length, and detect the frame start.
  always_comb begin
    p_next_s = p_r;
    if (p_r == PW'(FRAME_W - 1)) begin
      p_next_s = '0;
    end else begin
      p_next_s = p_r + PW'(1);
    end
    load_s = fall_s && (p_next_s == '0);
  end

  // WS level for the bit position that the next fall event makes current.
  always_comb begin
    ws_next_s = 1'b0;
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
    if (p_next_s >= PW'(SLOT_W)) begin
      ws_next_s = 1'b1;
    end else begin
      ws_next_s = 1'b0;
    end
`else
    if ((p_next_s >= PW'(SLOT_W - 1)) && (p_next_s <= PW'(FRAME_W - 2))) begin
      ws_next_s = 1'b1;
    end else begin
      ws_next_s = 1'b0;
    end
`endif
  end

  // FIFO status and handshake. Pops happen only at a frame start.
  always_comb begin
    empty_s = (level_r == LW'(0));
    full_s  = (level_r == LW'(FIFO_DEPTH));
    ready_s = !full_s && i_enable;
    push_s  = i_valid && ready_s;
    pop_s   = load_s && !empty_s;
    head_s  = mem_r[rd_ptr_r];
  end

  // Build the outgoing frame: left sample MSB-aligned in slot 0, right in slot 1.
  // The padding bits are zero. An empty FIFO yields a mute frame.
  always_comb begin
    frame_s = '0;
    if (empty_s) begin
      frame_s = '0;
    end else begin
      frame_s[FRAME_W-1 -: SAMPLE_W] = head_s[PAIR_W-1 -: SAMPLE_W];
      frame_s[SLOT_W-1 -: SAMPLE_W]  = head_s[SAMPLE_W-1:0];
    end
  end

  // BCK divider: toggle BCK each BCK_HALF cycles. Start low from idle.
  always_ff @(posedge i_clk) begin
    if (clear_s) begin
      cnt_r <= '0;
      bck_r <= 1'b0;
    end else if (tick_s) begin
      cnt_r <= '0;
      bck_r <= ~bck_r;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  // Serializer: on each fall event, step p, update WS, and shift out the next bit.
  always_ff @(posedge i_clk) begin
    if (clear_s) begin
      p_r        <= PW'(FRAME_W - 1);
      shreg_r    <= '0;
      ws_r       <= 1'b0;
      data_r     <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      underrun_r <= load_s && empty_s;
      if (fall_s) begin
        p_r  <= p_next_s;
        ws_r <= ws_next_s;
        if (load_s) begin
          data_r  <= frame_s[FRAME_W-1];
          shreg_r <= {frame_s[FRAME_W-2:0], 1'b0};
        end else begin
          data_r  <= shreg_r[FRAME_W-1];
          shreg_r <= {shreg_r[FRAME_W-2:0], 1'b0};
        end
      end
    end
  end

  // FIFO control: pointers and occupancy. Disable flushes the FIFO, as reset does.
  always_ff @(posedge i_clk) begin
    if (clear_s) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // FIFO storage: store each accepted pair as {left, right}.
  always_ff @(posedge i_clk) begin
    if (push_s && !clear_s) begin
      mem_r[wr_ptr_r] <= {i_left, i_right};
    end
  end

  assign o_ready    = ready_s;
  assign o_bck      = bck_r;
  assign o_ws       = ws_r;
  assign o_data     = data_r;
  assign o_underrun = underrun_r;
  assign o_level    = level_r;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// tb_i2s_tx_serializer: randomized scoreboard bench for i2s_tx_serializer.
// The driver pushes each accepted pair's expected 64-bit frame into a queue.
// The monitor follows the timing from elapsed cycles, pops a frame at each
// frame start and compares BCK, WS, DATA, underrun, level and ready.
module tb_i2s_tx_serializer;

  localparam int SAMPLE_W   = 24;
  localparam int SLOT_W     = 32;
  localparam int BCK_HALF   = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int FRAME_W    = 2 * SLOT_W;
  localparam int PAD        = SLOT_W - SAMPLE_W;

  typedef struct {
    logic [FRAME_W-1:0] frame;
    int                 stamp;
  } ent_t;

  logic                clk = 1'b0;
  logic                i_rst;
  logic                i_enable;
  logic [SAMPLE_W-1:0] i_left;
  logic [SAMPLE_W-1:0] i_right;
  logic                i_valid;
  logic                o_ready;
  logic                o_bck;
  logic                o_ws;
  logic                o_data;
  logic                o_underrun;
  logic [2:0]          o_level;

  int   vectors = 0;
  int   miscompares = 0;
  int   edge_cnt = 0;
  bit   rst_s = 1'b0;
  bit   en_s = 1'b1;
  ent_t q[$];

  i2s_tx_serializer #(
    .SAMPLE_W(SAMPLE_W), .SLOT_W(SLOT_W), .BCK_HALF(BCK_HALF), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_enable(i_enable), .i_left(i_left),
    .i_right(i_right), .i_valid(i_valid), .o_ready(o_ready), .o_bck(o_bck),
    .o_ws(o_ws), .o_data(o_data), .o_underrun(o_underrun), .o_level(o_level)
  );

  always #5 clk = ~clk;

  // Record the control inputs that each rising edge sampled.
  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    rst_s    <= i_rst;
    en_s     <= i_enable;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_cnt, act, exp);
    end
  endtask

  function automatic logic [FRAME_W-1:0] mkframe(input logic [SAMPLE_W-1:0] l,
                                                 input logic [SAMPLE_W-1:0] r);
    logic [FRAME_W-1:0] lw, rw;
    lw = FRAME_W'(l);
    rw = FRAME_W'(r);
    return (lw << (SLOT_W + PAD)) | (rw << PAD);
  endfunction

  // Drive one cycle (entered at posedge+1). The pair is accepted if o_ready is high before the edge.
  task automatic drive(input bit v, input logic [SAMPLE_W-1:0] l,
                       input logic [SAMPLE_W-1:0] r, output bit acc);
    ent_t e;
    i_valid = v;
    i_left  = l;
    i_right = r;
    #1;
    acc = v && o_ready && !i_rst && i_enable;
    @(posedge clk);
    #1;
    if (acc) begin
      e.frame = mkframe(l, r);
      e.stamp = edge_cnt;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, acc);
  endtask

  task automatic try_push(input logic [SAMPLE_W-1:0] l, input logic [SAMPLE_W-1:0] r,
                          input int max_wait);
    bit acc;
    int w;
    acc = 1'b0;
    w = 0;
    while (!acc && w < max_wait) begin
      drive(1'b1, l, r, acc);
      w++;
    end
    i_valid = 1'b0;
    vectors++;
    if (!acc) begin
      miscompares++;
      $display("FAIL push_accept: got not accepted after %0d cycles, expected accepted", w);
    end
  endtask

  // Monitor/scoreboard: reference timing from the cycle count since the last clear.
  int                 n = 0;
  int                 p = 0;
  bit                 seen = 1'b0;
  logic [FRAME_W-1:0] cur = '0;
  logic               e_data = 1'b0;
  logic               e_ws = 1'b0;
  logic               e_und = 1'b0;

  always @(negedge clk) begin
    if (rst_s || !en_s) begin
      seen   = 1'b1;
      n      = 0;
      q.delete();
      cur    = '0;
      e_data = 1'b0;
      e_ws   = 1'b0;
      e_und  = 1'b0;
    end else if (seen) begin
      n++;
      e_und = 1'b0;
      if (n % (2 * BCK_HALF) == 0) begin
        p = (n / (2 * BCK_HALF) - 1) % FRAME_W;
        if (p == 0) begin
          if (q.size() > 0 && q[0].stamp < edge_cnt) begin
            cur = q[0].frame;
            q.pop_front();
          end else begin
            cur   = '0;
            e_und = 1'b1;
          end
        end
        e_data = cur[FRAME_W-1-p];
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
        e_ws = (p >= SLOT_W);
`else
        e_ws = (p >= SLOT_W - 1) && (p <= FRAME_W - 2);
`endif
      end
    end
    if (seen) begin
      check("bck",      32'(o_bck),      32'((n / BCK_HALF) % 2));
      check("ws",       32'(o_ws),       32'(e_ws));
      check("data",     32'(o_data),     32'(e_data));
      check("underrun", 32'(o_underrun), 32'(e_und));
      check("level",    32'(o_level),    32'(q.size()));
      check("ready",    32'(o_ready),    32'((q.size() != FIFO_DEPTH) && i_enable));
    end
  end

  // Stimulus: directed scenarios first, then randomized traffic.
  initial begin
    bit acc;
    i_rst = 1'b1; i_enable = 1'b1; i_valid = 1'b0; i_left = '0; i_right = '0;
    repeat (3) @(posedge clk);
    #1;
    i_rst = 1'b0;
    // Known pair before the first fall, then an empty FIFO at the next frame start.
    try_push(24'hA5A5A5, 24'h5A5A5A, 10);
    idle(300);
    // Five back-to-back pairs. The fifth waits for a frame-start pop.
    for (int i = 0; i < 5; i++) try_push(24'($urandom), 24'($urandom), 300);
    idle(200);
    i_rst = 1'b1; idle(1); i_rst = 1'b0;
    // Reset in the middle of a frame while the FIFO holds data.
    for (int i = 0; i < 3; i++) try_push(24'($urandom), 24'($urandom), 10);
    idle(160);
    i_rst = 1'b1; idle(1); i_rst = 1'b0;
    idle(20);
    // While disabled, the FIFO stays flushed and o_ready stays low.
    i_enable = 1'b0;
    for (int i = 0; i < 20; i++) drive(1'b1, 24'($urandom), 24'($urandom), acc);
    i_enable = 1'b1;
    i_valid = 1'b0;
    idle(10);
    // Heavy random traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      i_rst = ($urandom_range(0, 399) == 0);
      drive($urandom_range(0, 7) == 0, 24'($urandom), 24'($urandom), acc);
    end
    i_rst = 1'b0;
    // Sparse random traffic with brief disables. Underruns are likely here.
    for (int i = 0; i < 1500; i++) begin
      i_enable = !($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 299) == 0, 24'($urandom), 24'($urandom), acc);
    end
    i_enable = 1'b1;
    idle(300);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Stop a run that hangs.
  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected completion before time limit");
    $fatal(1);
  end

endmodule
